instr_align_buffer: RTL

INSTR_ALIGN_BUFFER -- requirements
Module: instr_align_buffer

---
 rtl/instr_align_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/instr_align_buffer.sv
// instr_align_buffer
//   Realigns a stream of word-aligned 32-bit fetch words into whole
//   instructions. The buffer is a 4-entry circular queue of halfwords.
//   A 16-bit (compressed) instruction may start at any halfword. A 32-bit
//   instruction may straddle two fetch words.
//
//   Build option: define C_EXT_EN to enable compressed-instruction support.
//   When C_EXT_EN is undefined:
//     - every head halfword is treated as the start of a 32-bit instruction;
//     - the SKIP state does not exist;
//     - flush_pc_i[1] does not select a partial first word;
//     - pc always advances by 4.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   fetch_valid_i    fetch_data_i carries a word-aligned fetch word
//   fetch_ready_o    a fetch word is accepted this cycle when valid
//   fetch_data_i     fetch word, little-endian ([15:0] is the lower halfword)
//   flush_i          redirect: drop buffered halfwords, load flush_pc_i
//   flush_pc_i       redirect target (halfword aligned)
//   instr_valid_o    instr_o/instr_is_c_o/instr_pc_o hold one instruction
//   instr_ready_i    consumer takes the instruction this cycle
//   instr_o          raw instruction (compressed: upper half zero)
//   instr_is_c_o     instr_o is a 16-bit instruction
//   instr_pc_o       address of instr_o
module instr_align_buffer #(
    parameter int unsigned    PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0000_0000_8000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flush_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic            instr_is_c_o,
    output logic [PC_W-1:0] instr_pc_o
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

`ifdef C_EXT_EN
    typedef enum logic {RUN, SKIP} state_t;
`else
    typedef enum logic {RUN} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [PTR_W-1:0] head, head_next;
    logic [PC_W-1:0]  pc, pc_next;
    logic [15:0]      q [DEPTH];

    logic [PTR_W-1:0] tail;
    logic [15:0]      head_hw;
    logic [15:0]      next_hw;
    logic             head_is_c;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] pop_n;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] count_after_pop;

    logic             wr0_en;
    logic [PTR_W-1:0] wr0_idx;
    logic [15:0]      wr0_data;
    logic             wr1_en;
    logic [PTR_W-1:0] wr1_idx;

    // Queue head view and append position
    assign tail    = PTR_W'(head + PTR_W'(count));
    assign head_hw = q[head];
    assign next_hw = q[PTR_W'(head + PTR_W'(1))];

    // Instruction length decode of the head halfword
`ifdef C_EXT_EN
    assign head_is_c = (head_hw[1:0] != 2'b11);
`else
    assign head_is_c = 1'b0;
`endif

    // A whole instruction is present at the head
    assign instr_valid_o = (state == RUN) && !flush_i &&
                           (head_is_c ? (count >= CNT_W'(1)) : (count >= CNT_W'(2)));

    assign pop             = instr_valid_o && instr_ready_i;
    assign pop_n           = pop ? (head_is_c ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
    assign count_after_pop = count - pop_n;

    // Accept a word only if both its halfwords fit after this cycle's pop
    assign fetch_ready_o = !flush_i && (count_after_pop <= CNT_W'(2));
    assign push          = fetch_valid_i && fetch_ready_o;

    // Instruction outputs are zeroed while nothing is valid
    assign instr_o      = !instr_valid_o ? 32'h0 :
                          head_is_c      ? {16'h0, head_hw} : {next_hw, head_hw};
    assign instr_is_c_o = instr_valid_o && head_is_c;
    // pc is also shown during reset so the reset vector is visible
    assign instr_pc_o   = (instr_valid_o || rst_i) ? pc : PC_W'(0);

    // Next-state, queue write and pc update
    always_comb begin
        state_next = state;
        count_next = count;
        head_next  = head;
        pc_next    = pc;
        push_n     = CNT_W'(0);
        wr0_en     = 1'b0;
        wr0_idx    = tail;
        wr0_data   = fetch_data_i[15:0];
        wr1_en     = 1'b0;
        wr1_idx    = PTR_W'(tail + PTR_W'(1));

        if (flush_i) begin
            count_next = CNT_W'(0);
            pc_next    = flush_pc_i;
`ifdef C_EXT_EN
            state_next = flush_pc_i[1] ? SKIP : RUN;
`else
            state_next = RUN;
`endif
        end else begin
            if (pop) begin
                head_next = PTR_W'(head + PTR_W'(pop_n));
                pc_next   = pc + (head_is_c ? PC_W'(2) : PC_W'(4));
            end
            if (push) begin
`ifdef C_EXT_EN
                if (state == SKIP) begin
                    // Redirect landed on the upper half: keep only [31:16]
                    wr0_en     = 1'b1;
                    wr0_data   = fetch_data_i[31:16];
                    push_n     = CNT_W'(1);
                    state_next = RUN;
                end else begin
                    wr0_en = 1'b1;
                    wr1_en = 1'b1;
                    push_n = CNT_W'(2);
                end
`else
                wr0_en = 1'b1;
                wr1_en = 1'b1;
                push_n = CNT_W'(2);
`endif
            end
            count_next = count_after_pop + push_n;
        end
    end

    // Control state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            count <= CNT_W'(0);
            head  <= PTR_W'(0);
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            count <= count_next;
            head  <= head_next;
            pc    <= pc_next;
        end
    end

    // Halfword storage; contents are only observed through count
    always_ff @(posedge clk_i) begin
        if (wr0_en) begin
            q[wr0_idx] <= wr0_data;
        end
        if (wr1_en) begin
            q[wr1_idx] <= fetch_data_i[31:16];
        end
    end

endmodule
